simon_display_mux: RTL and testbench

- Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 2-digit score display in the Simon game.
- Takes a binary value and converts it to BCD with a sequential double-dabble.
- Scans one digit per millisecond with a one-clock dead time between digits; supports polarity inversion and overflow indication.
- Sits between the game core (score/level source) and the segment/digit pads.

---
 rtl/simon_display_mux_if.sv | 14 +
 rtl/simon_display_mux.sv | 203 ++++++++++++++++++++
 tb/tb_simon_display_mux.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/simon_display_mux_if.sv
// rtl/simon_display_mux_if.sv - value load handshake between game core and display mux
//   value       : binary value to display
//   value_valid : one-cycle load strobe, accepted only while busy is low
//   busy        : conversion in progress
interface simon_display_mux_if #(
  parameter int VALUE_WIDTH = 7
);
  logic [VALUE_WIDTH-1:0] value;
  logic                   value_valid;
  logic                   busy;

  modport master (output value, output value_valid, input busy);
  modport slave  (input value, input value_valid, output busy);
endinterface

// File: rtl/simon_display_mux.sv
// rtl/simon_display_mux.sv - N-digit multiplexed 7-segment driver with sequential binary-to-BCD
//   clk, rst_n      : clock, asynchronous active-low reset
//   ticks_per_milli : scan period in clocks (0 behaves as 1)
//   bus (slave)     : value / value_valid / busy load handshake
//   blank           : force all digits off (registered)
//   segments_invert : combinational polarity flip of segments and segment_digits
//   segments        : a..g on bits 0..6
//   segment_digits  : one-hot digit enable, bit0 = least significant digit
//   Optional macro SIMON_DISPLAY_LZB_EN enables leading-zero blanking.
module simon_display_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int VALUE_WIDTH = 7,
  parameter int TICK_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TICK_WIDTH-1:0] ticks_per_milli,
  simon_display_mux_if.slave    bus,
  input  logic                  blank,
  input  logic                  segments_invert,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] segment_digits
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  localparam int BCD_DIGITS = dec_digits(VALUE_WIDTH);
  // Scratch is never narrower than the display so the low-digit copy is always in range.
  localparam int SCR_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int SW = 4 * SCR_DIGITS;
  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(VALUE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_nx;
  logic [VALUE_WIDTH-1:0] val_sr;
  logic [SW-1:0]          scratch, scratch_adj;
  logic [CW-1:0]          shift_cnt;
  logic [DW-1:0]          disp;
  logic                   overflow;

  logic [TICK_WIDTH-1:0]  ms_cnt, ms_last;
  logic                   wrap, dead;
  logic [IW-1:0]          idx;
  logic [3:0]             sel_nib;
  logic [6:0]             seg_nx, raw_seg;
  logic [NUM_DIGITS-1:0]  dig_nx, raw_dig;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.value_valid) state_nx = SHIFT;
      SHIFT:   if (shift_cnt == CW'(1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_sr    <= '0;
      scratch   <= '0;
      shift_cnt <= '0;
      disp      <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.value_valid) begin
          val_sr    <= bus.value;
          scratch   <= '0;
          shift_cnt <= CW'(VALUE_WIDTH);
        end
        SHIFT: begin
          scratch   <= {scratch_adj[SW-2:0], val_sr[VALUE_WIDTH-1]};
          val_sr    <= val_sr << 1;
          shift_cnt <= shift_cnt - CW'(1);
        end
        COMMIT: begin
          // On overflow the previous display contents are kept; the dash overrides them.
          if (|(scratch >> DW)) begin
            overflow <= 1'b1;
          end else begin
            overflow <= 1'b0;
            disp     <= scratch[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- scanner ----------------
  // Compare against the live input so a period change applies at the next wrap,
  // and a counter already past the new limit wraps immediately.
  assign ms_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - TICK_WIDTH'(1);
  assign wrap    = (ms_cnt >= ms_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
      dead   <= 1'b1;
      idx    <= '0;
    end else begin
      ms_cnt <= wrap ? '0 : ms_cnt + TICK_WIDTH'(1);
      // The dead cycle takes priority so a period of 1 still yields active/dead alternation.
      if (dead) begin
        dead <= 1'b0;
        idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else if (wrap) begin
        dead <= 1'b1;
      end
    end
  end

  assign sel_nib = disp[4*idx +: 4];

`ifdef SIMON_DISPLAY_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  above_zero;

  // lz[k]: nibble k and every higher nibble are zero.
  always_comb begin
    lz         = '0;
    above_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      above_zero = above_zero & (disp[4*k +: 4] == 4'd0);
      lz[k]      = above_zero;
    end
  end
`endif

  always_comb begin
    dig_nx = '0;
    seg_nx = '0;
    if (!dead && !blank) begin
      dig_nx = NUM_DIGITS'(1) << idx;
      if (overflow) seg_nx = 7'h40;
      else          seg_nx = glyph(sel_nib);
`ifdef SIMON_DISPLAY_LZB_EN
      if (!overflow && (idx != '0) && lz[idx]) seg_nx = 7'h00;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_seg <= '0;
      raw_dig <= '0;
    end else begin
      raw_seg <= seg_nx;
      raw_dig <= dig_nx;
    end
  end

  assign segments       = raw_seg ^ {7{segments_invert}};
  assign segment_digits = raw_dig ^ {NUM_DIGITS{segments_invert}};

endmodule

// File: tb/tb_simon_display_mux.sv
// tb/tb_simon_display_mux.sv - directed self-checking bench for simon_display_mux (2 digits, 7-bit value)
module tb_simon_display_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ticks_per_milli;
  logic        blank;
  logic        segments_invert;
  logic [6:0]  segments;
  logic [1:0]  segment_digits;

  int passed = 0;
  int total  = 0;
  int n;
  int m;

  simon_display_mux_if #(.VALUE_WIDTH(7)) bus ();

  simon_display_mux #(.NUM_DIGITS(2), .VALUE_WIDTH(7), .TICK_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ticks_per_milli (ticks_per_milli),
    .bus             (bus),
    .blank           (blank),
    .segments_invert (segments_invert),
    .segments        (segments),
    .segment_digits  (segment_digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to the first negedge where digit d turns on after a dark sample.
  task automatic wait_start(input logic [1:0] d, input string tag);
    logic [1:0] prev;
    bit found;
    prev  = segment_digits;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (prev == 2'b00 && segment_digits == d) found = 1;
      prev = segment_digits;
    end
    if (!found) begin
      total++;
      $error("FAIL %s timeout waiting for digit %b observed=%b", tag, d, segment_digits);
    end
  endtask

  task automatic strobe(input logic [6:0] v);
    bus.value       = v;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    if (bus.busy) begin
      total++;
      $error("FAIL %s busy timeout", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    ticks_per_milli = 16'd4;
    blank           = 1'b0;
    segments_invert = 1'b0;
    bus.value       = '0;
    bus.value_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a conversion, inverted polarity.
    strobe(7'd42);
    @(negedge clk);
    check("busy_mid_conv", bus.busy, 1'b1);
    segments_invert = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_segments_inv", segments, 7'h7F);
    check("rst_digits_inv", segment_digits, 2'b11);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    segments_invert = 1'b0;
    rst_n = 1'b1;

    wait_start(2'b01, "post_rst_d0");
    check("post_rst_d0_seg", segments, 7'h3F);
    wait_start(2'b10, "post_rst_d1");
`ifdef SIMON_DISPLAY_LZB_EN
    check("post_rst_d1_seg", segments, 7'h00);
`else
    check("post_rst_d1_seg", segments, 7'h3F);
`endif

    // 42 -> digit0 '2', digit1 '4'; busy lasts VALUE_WIDTH+1 cycles.
    bus.value       = 7'd42;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 8);
    wait_start(2'b01, "v42_d0");
    check("v42_d0_seg", segments, 7'h5B);
    n = 0;
    while (segment_digits == 2'b01 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("active_clocks", n, 3);
    m = 0;
    while (segment_digits == 2'b00 && m < 10) begin
      m++;
      @(negedge clk);
    end
    check("dead_clocks", m, 1);
    check("next_digit", segment_digits, 2'b10);
    check("v42_d1_seg", segments, 7'h66);

    // Overflow, then recovery.
    strobe(7'd100);
    wait_idle("v100");
    wait_start(2'b01, "v100_d0");
    check("v100_d0_seg", segments, 7'h40);
    wait_start(2'b10, "v100_d1");
    check("v100_d1_seg", segments, 7'h40);

    strobe(7'd99);
    wait_idle("v99");
    wait_start(2'b01, "v99_d0");
    check("v99_d0_seg", segments, 7'h6F);
    wait_start(2'b10, "v99_d1");
    check("v99_d1_seg", segments, 7'h6F);

    // Second strobe while busy is dropped.
    strobe(7'd5);
    @(negedge clk);
    strobe(7'd9);
    wait_idle("collision");
    wait_start(2'b01, "coll_d0");
    check("coll_d0_seg", segments, 7'h6D);
    wait_start(2'b10, "coll_d1");
`ifdef SIMON_DISPLAY_LZB_EN
    check("coll_d1_seg", segments, 7'h00);
`else
    check("coll_d1_seg", segments, 7'h3F);
`endif

    // Blank for exactly one scan period starting at digit0; digit1 follows on release.
    wait_start(2'b01, "blank_sync");
    blank = 1'b1;
    @(negedge clk);
    check("blank_digits", segment_digits, 2'b00);
    check("blank_segments", segments, 7'h00);
    segments_invert = 1'b1;
    #1;
    check("blank_digits_inv", segment_digits, 2'b11);
    check("blank_segments_inv", segments, 7'h7F);
    segments_invert = 1'b0;
    repeat (3) @(negedge clk);
    blank = 1'b0;
    check("blank_lag", segment_digits, 2'b00);
    @(negedge clk);
    check("unblank_resume", segment_digits, 2'b10);

    // Period 0 behaves as 1: one active + one dead clock per digit.
    ticks_per_milli = 16'd0;
    repeat (10) @(negedge clk);
    wait_start(2'b01, "tpm0_sync");
    @(negedge clk);
    check("tpm0_dead_a", segment_digits, 2'b00);
    @(negedge clk);
    check("tpm0_d1", segment_digits, 2'b10);
    @(negedge clk);
    check("tpm0_dead_b", segment_digits, 2'b00);
    @(negedge clk);
    check("tpm0_d0", segment_digits, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
